// File: rtl/btn_debounce_core.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce_core
//  Description : FPro MMIO button slot. Synchronizes and debounces W button
//                inputs and exposes debounced level, synchronized level and
//                sticky write-1-to-clear rising/falling edge flags.
//  Revision    : 1.0  initial release
// ============================================================================
module btn_debounce_core #(
   parameter int W = 5,
   parameter int N = 20
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         cs,
   input  logic         read,
   input  logic         write,
   input  logic [4:0]   addr,
   output logic [31:0]  rd_data,
   input  logic [31:0]  wr_data,
   input  logic [W-1:0] din
);

   localparam logic [N-1:0] CNT_MAX = '1;

   logic [W-1:0] sync_meta;
   logic [W-1:0] sync;
   logic [N-1:0] cnt [W];
   logic [W-1:0] db;
   logic [W-1:0] rise;
   logic [W-1:0] fall;
   logic [W-1:0] db_set;
   logic [W-1:0] db_clr;
   logic [W-1:0] rise_clr;
   logic [W-1:0] fall_clr;

   // Reads are decoded purely from addr, so the read strobe and the upper
   // write-data bits carry no information for this slot.
   logic unused_bits;
   assign unused_bits = ^{read, wr_data};

   // Two-flop synchronizer for the asynchronous button inputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_meta <= '0;
         sync      <= '0;
      end else begin
         sync_meta <= din;
         sync      <= sync_meta;
      end
   end

   // A bit flips only on the last clock of a full mismatch window.
   always_comb begin
      db_set = '0;
      db_clr = '0;
      for (int i = 0; i < W; i++) begin
         if (sync[i] != db[i] && cnt[i] == CNT_MAX) begin
            db_set[i] = sync[i];
            db_clr[i] = ~sync[i];
         end
      end
   end

   // Per-bit stability counters; any matching cycle restarts the window.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < W; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < W; i++) begin
            if (sync[i] == db[i] || cnt[i] == CNT_MAX) begin
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   // Software clear masks for the edge flags (write-1-to-clear).
   always_comb begin
      rise_clr = '0;
      fall_clr = '0;
      if (cs && write && addr == 5'd2) begin
         rise_clr = wr_data[W-1:0];
      end
      if (cs && write && addr == 5'd3) begin
         fall_clr = wr_data[W-1:0];
      end
   end

   // Debounced level and sticky edge flags; a new edge beats a same-cycle clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         db   <= '0;
         rise <= '0;
         fall <= '0;
      end else begin
         db   <= (db | db_set) & ~db_clr;
         rise <= (rise & ~rise_clr) | db_set;
         fall <= (fall & ~fall_clr) | db_clr;
      end
   end

   // Combinational read mux; only word addresses 0..3 are populated.
   always_comb begin
      rd_data = '0;
      if (addr[4:2] == 3'b000) begin
         case (addr[1:0])
            2'd0:    rd_data[W-1:0] = db;
            2'd1:    rd_data[W-1:0] = sync;
            2'd2:    rd_data[W-1:0] = rise;
            default: rd_data[W-1:0] = fall;
         endcase
      end
   end

endmodule
`default_nettype wire
